sd_pixel_window: RTL
====================

// Module: sd_pixel_window
// PURPOSE
// - Converts the SD-card read byte stream (one byte per in_en strobe) into BPP-byte pixels.
// - Crops a runtime-programmable window out of a larger raw frame.
// - Produces pixel valid, start-of-frame and end-of-line markers for the ISP/HDMI pipeline.
// - Parametrised successor to the fixed 16-bit, fixed-origin SD image extractor.
// - Adds: header skip, window offset, byte order select, frame restart and a frame counter.
// PARAMETERS
// BPP       2     bytes per pixel (1..4); PIX_W = 8*BPP
// H_IMG     1936  raw frame width in pixels
// V_IMG     1088  raw frame height in lines
// H_VALID   1024  window width in pixels
// V_VALID   768   window height in lines
// HDR_BYTES 0     bytes discarded at start of every frame (0 = none)
// CW        12    width of h/v counters and offset inputs
// PORTS
// clk           in   1      system clock (SD data side)
// rst           in   1      asynchronous reset, active-high
// in_en         in   1      input byte valid strobe, any duty cycle
// in_byte       in   8      input byte
// frame_restart in   1      synchronous resync pulse: next byte is byte 0 of a frame
// cfg_h_start   in   CW     window x origin in pixels
// cfg_v_start   in   CW     window y origin in lines
// cfg_lsb_first in   1      0: first byte -> MSB; 1: first byte -> LSB
// pix_data      out  PIX_W  packed pixel
// pix_en        out  1      pixel valid, one-cycle pulse
// pix_sof       out  1      with pix_en: first window pixel of the frame
// pix_eol       out  1      with pix_en: last window pixel of a line
// frame_done    out  1      one-cycle pulse after the last raw byte of a frame
// frame_cnt     out  16     completed frames, wraps at 0xFFFF->0
// BEHAVIOUR
// Reset values
// - All outputs 0; state = S_HDR (or S_PIX when HDR_BYTES == 0); all counters 0.
// - Reset has immediate effect mid-frame; no partial pixel is emitted.
// FSM
// - S_HDR: count in_en bytes; on byte HDR_BYTES-1 go to S_PIX.
// - S_PIX: pack bytes; on the last byte of pixel (H_IMG-1, V_IMG-1) pulse frame_done,
//   increment frame_cnt, and return to S_HDR (S_PIX if HDR_BYTES == 0).
// Packing
// - byte_cnt runs 0..BPP-1 and advances only on in_en.
// - Shift direction follows cfg_lsb_first.
// - Pixel is complete on the in_en with byte_cnt == BPP-1.
// Latency
// - pix_en and pix_data are registered: 1 cycle after the completing in_en.
// - pix_data holds its value until the next pixel.
// Raster
// - hcnt 0..H_IMG-1 and vcnt 0..V_IMG-1 advance per completed pixel.
// - hcnt wraps and increments vcnt; both wrap at the frame end.
// Window
// - Pixel is emitted when h_start <= hcnt < h_start+H_VALID and v_start <= vcnt < v_start+V_VALID.
// - Comparisons use CW+1-bit sums (no overflow).
// - Window parts beyond H_IMG/V_IMG are simply never emitted.
// - pix_sof: hcnt == h_start and vcnt == v_start.
// - pix_eol: hcnt == h_start+H_VALID-1, or hcnt == H_IMG-1 inside the window.
// Config sampling
// - cfg_* latched into shadow registers at frame start (reset, frame_restart, frame wrap).
// - Mid-frame cfg changes take effect from the next frame.
// frame_restart
// - Highest priority.
// - Clears byte_cnt, hcnt, vcnt and the state (to the header state).
// - Discards the partial pixel and re-latches cfg.
// - frame_cnt and frame_done are not touched.
// - A coincident in_en byte is dropped.
// Gaps
// - No in_en means counters hold; gaps of any length are legal.
// STRUCTURE
// - Package sd_pix_pkg:
//   - state encoding S_HDR/S_PIX;
//   - function pix_w(BPP);
//   - default constants SD_H_IMG, SD_V_IMG, SD_H_VALID, SD_V_VALID.
// - Sub-module sd_byte_packer (BPP, lsb_first, restart) -> word + word_en.
//   - Instantiated once; raster counters, window compare and FSM stay in the top.
// TESTING
// T1 Use BPP=2, H_IMG=8, V_IMG=4, window 4x2 at (0,0), lsb_first=0; stream bytes 0x00,0x01,...
//    -> 8 pixels, first 0x0001, sof on first, eol on pixels 4 and 8 (0x0607, 0x1617).
// T2 Use offset (2,1), same stream -> first pixel 0x1415 with sof; 4 pixels per line; lines 1-2 only.
//    Then set lsb_first=1 mid-frame -> the change applies only from the next frame (0x0100 order).
// T3 Use HDR_BYTES=54, BPP=3 -> first 54 bytes emit nothing.
//    Byte 54 starts pixel 0; frame_done exactly once after 54+3*H_IMG*V_IMG bytes; frame_cnt=1.
// T4 Pulse frame_restart after 3 bytes of a 2-byte-pixel line, with in_en high in the same cycle
//    -> partial pixel discarded, that byte dropped, the next byte is MSB of pixel (0,0), sof reasserts.
// T5 Drive random in_en gaps (0-20 cycles) -> pix_data sequence identical to the gapless run.
//    Every pix_en comes exactly 1 cycle after the completing in_en.
// T6 Assert rst mid-pixel -> outputs 0 at once.
//    After release, stream 2 full frames -> frame_cnt=2 and two frame_done pulses.

Source files
------------

// File: rtl/sd_pixel_window_pkg.sv
// Shared types and defaults for the SD pixel window: FSM encoding, pixel width helper
// and the raw/window geometry of the production sensor frame.
package sd_pix_pkg;

  typedef enum logic {
    S_HDR = 1'b0,
    S_PIX = 1'b1
  } state_t;

  localparam int SD_H_IMG   = 1936;
  localparam int SD_V_IMG   = 1088;
  localparam int SD_H_VALID = 1024;
  localparam int SD_V_VALID = 768;

  function automatic int pix_w(input int bpp);
    return 8 * bpp;
  endfunction

endpackage

// File: rtl/sd_pixel_window_if.sv
// Byte stream in / pixel stream out bundle. The window block is the slave, the SD-side
// source (or a bench) is the master.
interface sd_pixel_window_if #(
  parameter int PIX_W = 16
);
  logic             in_en;
  logic [7:0]       in_byte;
  logic [PIX_W-1:0] pix_data;
  logic             pix_en;
  logic             pix_sof;
  logic             pix_eol;

  modport master (output in_en, in_byte, input pix_data, pix_en, pix_sof, pix_eol);
  modport slave  (input in_en, in_byte, output pix_data, pix_en, pix_sof, pix_eol);
endinterface

// File: rtl/sd_byte_packer.sv
// Packs BPP consecutive strobed bytes into one word. word/word_en are combinational and
// valid in the cycle of the completing byte; restart drops the partial word.
module sd_byte_packer
  import sd_pix_pkg::*;
#(
  parameter  int BPP   = 2,
  localparam int PIX_W = pix_w(BPP)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [7:0]       in_byte,
  input  logic             lsb_first,
  input  logic             restart,
  output logic [PIX_W-1:0] word,
  output logic             word_en
);

  localparam int BCW = (BPP > 1) ? $clog2(BPP) : 1;

  logic [BCW-1:0]   byte_cnt_q;
  logic [PIX_W-1:0] acc_q;
  logic [PIX_W-1:0] acc_next;
  logic             last_byte;

  assign last_byte = (byte_cnt_q == BCW'(BPP - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_next = (acc_q << 8) | PIX_W'(in_byte);
    if (lsb_first) acc_next = (acc_q >> 8) | (PIX_W'(in_byte) << (PIX_W - 8));
  end

  assign word    = acc_next;
  assign word_en = in_en && !restart && last_byte;

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      acc_q      <= '0;
    end else if (restart) begin
      byte_cnt_q <= '0;
    end else if (in_en) begin
      acc_q      <= acc_next;
      byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BCW'(1);
    end
  end

endmodule

// File: rtl/sd_pixel_window.sv
// Crops a programmable window out of a raw SD-card frame byte stream, with header skip,
// byte-order select, frame resync and a completed-frame counter.
module sd_pixel_window
  import sd_pix_pkg::*;
#(
  parameter  int BPP       = 2,
  parameter  int H_IMG     = SD_H_IMG,
  parameter  int V_IMG     = SD_V_IMG,
  parameter  int H_VALID   = SD_H_VALID,
  parameter  int V_VALID   = SD_V_VALID,
  parameter  int HDR_BYTES = 0,
  parameter  int CW        = 12,
  localparam int PIX_W     = pix_w(BPP)
) (
  input  logic          clk,
  input  logic          rst,
  sd_pixel_window_if.slave bus,
  input  logic          frame_restart,
  input  logic [CW-1:0] cfg_h_start,
  input  logic [CW-1:0] cfg_v_start,
  input  logic          cfg_lsb_first,
  output logic          frame_done,
  output logic [15:0]   frame_cnt
);

  localparam int     HCW    = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam state_t S_INIT = (HDR_BYTES == 0) ? S_PIX : S_HDR;

  state_t           state_q, state_d;
  logic [HCW-1:0]   hdr_cnt_q;
  logic [CW-1:0]    hcnt_q, vcnt_q;
  logic             at_sof_q;
  logic [CW-1:0]    h_start_q, v_start_q;
  logic             lsb_q;
  logic [CW-1:0]    h_start, v_start;
  logic             lsb_first;
  logic             hdr_byte, hdr_last;
  logic             h_last, v_last, frame_end;
  logic [PIX_W-1:0] word;
  logic             word_en;
  logic [CW:0]      hx, vx, hs, vs, he, ve;
  logic             in_win, at_origin, at_eol, emit;
  logic [PIX_W-1:0] pix_data_q;
  logic             pix_en_q, pix_sof_q, pix_eol_q;

  // Until the first byte of a frame is taken the live cfg inputs are used directly,
  // so the shadow copy is exactly what was presented with that first byte.
  assign h_start   = at_sof_q ? cfg_h_start   : h_start_q;
  assign v_start   = at_sof_q ? cfg_v_start   : v_start_q;
  assign lsb_first = at_sof_q ? cfg_lsb_first : lsb_q;

  assign hdr_byte  = bus.in_en && !frame_restart && (state_q == S_HDR);
  assign hdr_last  = (hdr_cnt_q == HCW'(HDR_BYTES - 1));

  sd_byte_packer #(.BPP(BPP)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .in_en     (bus.in_en && (state_q == S_PIX)),
    .in_byte   (bus.in_byte),
    .lsb_first (lsb_first),
    .restart   (frame_restart),
    .word      (word),
    .word_en   (word_en)
  );

  assign h_last    = (hcnt_q == CW'(H_IMG - 1));
  assign v_last    = (vcnt_q == CW'(V_IMG - 1));
  assign frame_end = word_en && h_last && v_last;

  // One extra bit keeps start+size from wrapping near the top of the CW range.
  assign hx = {1'b0, hcnt_q};
  assign vx = {1'b0, vcnt_q};
  assign hs = {1'b0, h_start};
  assign vs = {1'b0, v_start};
  assign he = hs + (CW + 1)'(H_VALID);
  assign ve = vs + (CW + 1)'(V_VALID);

  assign in_win    = (hx >= hs) && (hx < he) && (vx >= vs) && (vx < ve);
  assign at_origin = (hcnt_q == h_start) && (vcnt_q == v_start);
  assign at_eol    = (hx == he - (CW + 1)'(1)) || h_last;
  assign emit      = word_en && in_win;

  always_comb begin
    state_d = state_q;
    if (frame_restart)           state_d = S_INIT;
    else if (hdr_byte && hdr_last) state_d = S_PIX;
    else if (frame_end)          state_d = S_INIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt_q <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      at_sof_q  <= 1'b1;
      h_start_q <= '0;
      v_start_q <= '0;
      lsb_q     <= 1'b0;
    end else if (frame_restart) begin
      hdr_cnt_q <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      at_sof_q  <= 1'b1;
    end else begin
      if (hdr_byte) hdr_cnt_q <= hdr_last ? '0 : hdr_cnt_q + HCW'(1);
      if (bus.in_en && at_sof_q) begin
        at_sof_q  <= 1'b0;
        h_start_q <= h_start;
        v_start_q <= v_start;
        lsb_q     <= lsb_first;
      end
      if (word_en) begin
        if (h_last) begin
          hcnt_q <= '0;
          vcnt_q <= v_last ? '0 : vcnt_q + CW'(1);
        end else begin
          hcnt_q <= hcnt_q + CW'(1);
        end
        if (frame_end) at_sof_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_data_q <= '0;
      pix_en_q   <= 1'b0;
      pix_sof_q  <= 1'b0;
      pix_eol_q  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      pix_en_q   <= emit;
      pix_sof_q  <= emit && at_origin;
      pix_eol_q  <= emit && at_eol;
      frame_done <= frame_end;
      if (emit)      pix_data_q <= word;
      if (frame_end) frame_cnt  <= frame_cnt + 16'd1;
    end
  end

  assign bus.pix_data = pix_data_q;
  assign bus.pix_en   = pix_en_q;
  assign bus.pix_sof  = pix_sof_q;
  assign bus.pix_eol  = pix_eol_q;

endmodule
